// File: rtl/lcd_read_if.sv
// lcd_read_if -- request/response and LCD pin bundle for the HD44780 read driver.
//
// Request side : start, rs_sel             (requester -> driver)
// Response side: rdata, bf, addr, busy, done, timeout  (driver -> requester)
// LCD pins     : lcd_d (pin -> driver), rs, rw, en, bus_oe (driver -> pins)
//
// modport slave  : the lcd_read driver itself
// modport master : the requester / pin-level model
interface lcd_read_if;
  logic       start;
  logic       rs_sel;
  logic [7:0] lcd_d;
  logic       rs;
  logic       rw;
  logic       en;
  logic       bus_oe;
  logic [7:0] rdata;
  logic       bf;
  logic [6:0] addr;
  logic       busy;
  logic       done;
  logic       timeout;

  modport slave (
    input  start, rs_sel, lcd_d,
    output rs, rw, en, bus_oe, rdata, bf, addr, busy, done, timeout
  );

  modport master (
    output start, rs_sel, lcd_d,
    input  rs, rw, en, bus_oe, rdata, bf, addr, busy, done, timeout
  );
endinterface

// File: rtl/lcd_read.sv
// lcd_read -- HD44780-style 8-bit LCD read driver.
//
// Runs one read cycle per accepted request: rs/rw setup, an enable pulse
// during which the data bus is sampled, an enable-low hold, then a one-cycle
// done pulse. rs_sel=0 reads the busy flag / address counter, rs_sel=1 reads
// DDRAM/CGRAM data. The FPGA never drives the data bus (bus_oe stays 0); the
// top level hands the pins to this block while busy=1.
//
// Ports:
//   clk       in   main clock (22.1184 MHz)
//   rst       in   asynchronous, active-high reset
//   bus       lcd_read_if.slave:
//     start   in   one-cycle request, accepted only in IDLE
//     rs_sel  in   register select, latched on accept
//     lcd_d   in   LCD data bus as seen at the pin
//     rs/rw/en out LCD control pins
//     bus_oe  out  data-bus drive enable, constant 0
//     rdata   out  last captured byte
//     bf/addr out  rdata[7] / rdata[6:0] of the last rs_sel=0 read
//     busy    out  1 whenever not IDLE
//     done    out  one-cycle completion pulse
//     timeout out  poll limit reached, sticky until the next accept
//
// Optional feature macro: LCD_BUSY_POLL_EN
//   When defined, a status read that returns bf=1 is repeated (up to
//   MAX_POLLS reads) before done is raised; timeout flags the limit case.
//   When undefined, every request is a single read and timeout is 0.
module lcd_read #(
  parameter int unsigned T_AS      = 2,
  parameter int unsigned T_EH      = 12,
  parameter int unsigned T_SMP     = 9,
  parameter int unsigned T_EL      = 12,
  parameter int unsigned MAX_POLLS = 4095
) (
  input  logic       clk,
  input  logic       rst,
  lcd_read_if.slave  bus
);

  // Elaboration-time parameter range guards.
  if (T_AS < 1 || T_AS > 255) begin : g_bad_t_as
    $error("lcd_read: T_AS out of range 1..255");
  end
  if (T_EH < 2 || T_EH > 255) begin : g_bad_t_eh
    $error("lcd_read: T_EH out of range");
  end
  if (T_SMP < 1 || T_SMP > T_EH - 1) begin : g_bad_t_smp
    $error("lcd_read: T_SMP out of range 1..T_EH-1");
  end
  if (T_EL < 1 || T_EL > 255) begin : g_bad_t_el
    $error("lcd_read: T_EL out of range 1..255");
  end
  if (MAX_POLLS < 1 || MAX_POLLS > 4095) begin : g_bad_max_polls
    $error("lcd_read: MAX_POLLS out of range 1..4095");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EN_HI = 3'd2,
    S_EN_LO = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Terminal counts: each phase counts 0..N-1 and leaves on N-1.
  localparam logic [7:0] C_AS_LAST  = 8'(T_AS - 1);
  localparam logic [7:0] C_EH_LAST  = 8'(T_EH - 1);
  localparam logic [7:0] C_SMP_LAST = 8'(T_SMP - 1);
  localparam logic [7:0] C_EL_LAST  = 8'(T_EL - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_rs;
  logic       r_rw;
  logic       r_en;
  logic [7:0] r_rdata;
  logic       r_bf;
  logic [6:0] r_addr;
  logic       r_busy;
  logic       r_done;
  logic [7:0] w_cnt_inc;
  logic       w_repeat;

`ifdef LCD_BUSY_POLL_EN
  logic [11:0] r_polls;
  logic        r_timeout;
  logic [11:0] w_polls_inc;
  logic        w_limit;

  // Poll decision at the end of EN_LO: repeat a status read while the LCD
  // reports busy, unless this read brings the poll count to the limit.
  always_comb begin
    w_polls_inc = r_polls + 12'd1;
    w_repeat    = 1'b0;
    w_limit     = 1'b0;
    if (!r_rs && r_bf) begin
      if (w_polls_inc < 12'(MAX_POLLS)) begin
        w_repeat = 1'b1;
      end else begin
        w_limit = 1'b1;
      end
    end else begin
      w_repeat = 1'b0;
      w_limit  = 1'b0;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  // Saturating phase counter increment; it never wraps mid-phase.
  always_comb begin
    w_cnt_inc = r_cnt;
    if (r_cnt != 8'hFF) begin
      w_cnt_inc = r_cnt + 8'd1;
    end else begin
      w_cnt_inc = r_cnt;
    end
  end

  // Read-cycle sequencer with registered pin and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_rs      <= 1'b0;
      r_rw      <= 1'b0;
      r_en      <= 1'b0;
      r_rdata   <= 8'd0;
      r_bf      <= 1'b0;
      r_addr    <= 7'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      r_polls   <= 12'd0;
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_rs      <= bus.rs_sel;
            r_rw      <= 1'b1;
            r_cnt     <= 8'd0;
            r_busy    <= 1'b1;
            r_state   <= S_SETUP;
`ifdef LCD_BUSY_POLL_EN
            r_polls   <= 12'd0;
            r_timeout <= 1'b0;
`endif
          end
        end
        S_SETUP: begin
          if (r_cnt == C_AS_LAST) begin
            r_en    <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= S_EN_HI;
          end else begin
            r_cnt   <= w_cnt_inc;
          end
        end
        S_EN_HI: begin
          // Sample once the LCD's data-valid delay has elapsed; status
          // fields only follow status reads.
          if (r_cnt == C_SMP_LAST) begin
            r_rdata <= bus.lcd_d;
            if (!r_rs) begin
              r_bf   <= bus.lcd_d[7];
              r_addr <= bus.lcd_d[6:0];
            end
          end
          if (r_cnt == C_EH_LAST) begin
            r_en    <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_EN_LO;
          end else begin
            r_cnt   <= w_cnt_inc;
          end
        end
        S_EN_LO: begin
          if (r_cnt == C_EL_LAST) begin
            r_cnt <= 8'd0;
`ifdef LCD_BUSY_POLL_EN
            r_polls <= w_polls_inc;
`endif
            if (w_repeat) begin
              r_state <= S_SETUP;
            end else begin
              r_done  <= 1'b1;
              r_rs    <= 1'b0;
              r_rw    <= 1'b0;
              r_state <= S_FIN;
`ifdef LCD_BUSY_POLL_EN
              r_timeout <= w_limit;
`endif
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
          r_rs    <= 1'b0;
          r_rw    <= 1'b0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rs     = r_rs;
  assign bus.rw     = r_rw;
  assign bus.en     = r_en;
  assign bus.bus_oe = 1'b0;
  assign bus.rdata  = r_rdata;
  assign bus.bf     = r_bf;
  assign bus.addr   = r_addr;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
`ifdef LCD_BUSY_POLL_EN
  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_read.sv
// tb_lcd_read -- scoreboard bench for lcd_read.
// Stimulus pushes the expected completion (data, status, timeout, done cycle)
// into a queue; a monitor pops and compares whenever done is seen.
module tb_lcd_read;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_read_if bus ();
  lcd_read dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef LCD_BUSY_POLL_EN
  lcd_read_if bus2 ();
  lcd_read #(.MAX_POLLS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
`endif

  typedef struct {
    logic [7:0] rdata;
    logic       bf;
    logic [6:0] addr;
    logic       timeout;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rdata", bus.rdata, e.rdata);
        chk("bf", bus.bf, e.bf);
        chk("addr", bus.addr, e.addr);
        chk("timeout", bus.timeout, e.timeout);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // One read request. lcd_d starts at d0 and switches to d1 during en-high
  // cycle index sw (0-based). Returns after the FIN cycle so that the next
  // call issues start in the first IDLE cycle.
  task automatic do_read(input logic sel, input logic [7:0] d0, input logic [7:0] d1,
                         input int sw, input logic [7:0] e_rd, input logic e_bf,
                         input logic [6:0] e_ad, input bit chk_en, input bit poke);
    int   k;
    exp_t e;
    @(negedge clk);
    k = cyc;
    bus.start  = 1'b1;
    bus.rs_sel = sel;
    bus.lcd_d  = d0;
    e.rdata = e_rd; e.bf = e_bf; e.addr = e_ad; e.timeout = 1'b0; e.cyc = k + 27;
    q.push_back(e);
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      bus.start = (poke && i == 6);
      if (i == 3 + sw) bus.lcd_d = d1;
      if (chk_en) chk("en_window", bus.en, (i >= 3 && i <= 14));
      if (i == 3) begin
        chk("rs_pin", bus.rs, sel);
        chk("rw_pin", bus.rw, 1);
      end
    end
    chk("busy_in_fin", bus.busy, 1);
    chk("rw_in_fin", bus.rw, 0);
    chk("rs_in_fin", bus.rs, 0);
  endtask

  logic       pbf;
  logic [6:0] pad;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.rs_sel = 1'b0; bus.lcd_d = 8'h00;
`ifdef LCD_BUSY_POLL_EN
    bus2.start = 1'b0; bus2.rs_sel = 1'b0; bus2.lcd_d = 8'hFF;
`endif
    repeat (3) @(negedge clk);
    chk("rst_rs", bus.rs, 0);
    chk("rst_rw", bus.rw, 0);
    chk("rst_en", bus.en, 0);
    chk("rst_bus_oe", bus.bus_oe, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_bf", bus.bf, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", bus.timeout, 0);
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_en_rw_busy", {bus.en, bus.rw, bus.busy}, 3'b000);
    end

    // Status read: bf=0, addr=4F.
    do_read(1'b0, 8'h4F, 8'h4F, 99, 8'h4F, 1'b0, 7'h4F, 1'b0, 1'b0);
    pbf = 1'b0; pad = 7'h4F;
`ifndef LCD_BUSY_POLL_EN
    // Status read with bf set (single read when polling is not built).
    do_read(1'b0, 8'hC3, 8'hC3, 99, 8'hC3, 1'b1, 7'h43, 1'b0, 1'b0);
    pbf = 1'b1; pad = 7'h43;
`endif
    // Data read: bf/addr hold, enable window checked.
    do_read(1'b1, 8'hA5, 8'hA5, 99, 8'hA5, pbf, pad, 1'b1, 1'b0);
    // Sample point: change during en-high cycle 8 is captured, cycle 9 is not.
    do_read(1'b1, 8'h00, 8'h3C, 8, 8'h3C, pbf, pad, 1'b0, 1'b0);
    do_read(1'b1, 8'h00, 8'h3C, 9, 8'h00, pbf, pad, 1'b0, 1'b0);
    // Start pulsed during EN_HI is ignored.
    do_read(1'b1, 8'h5A, 8'h5A, 99, 8'h5A, pbf, pad, 1'b0, 1'b1);
    repeat (40) @(negedge clk);

    // Reset in the middle of EN_HI.
    @(negedge clk);
    bus.start = 1'b1; bus.rs_sel = 1'b1; bus.lcd_d = 8'h77;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("en_before_rst", bus.en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_en", bus.en, 0);
    chk("rst_mid_rw", bus.rw, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_rdata", bus.rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_after_rst", bus.busy, 0);
    do_read(1'b0, 8'h4F, 8'h4F, 99, 8'h4F, 1'b0, 7'h4F, 1'b0, 1'b0);

`ifdef LCD_BUSY_POLL_EN
    // Busy for three reads, then 12: four pulses and one done.
    begin
      int   k, rises;
      logic pen;
      exp_t e;
      @(negedge clk);
      k = cyc; rises = 0; pen = 1'b0;
      bus.start = 1'b1; bus.rs_sel = 1'b0; bus.lcd_d = 8'h80;
      e.rdata = 8'h12; e.bf = 1'b0; e.addr = 7'h12; e.timeout = 1'b0; e.cyc = k + 105;
      q.push_back(e);
      for (int i = 1; i <= 110; i++) begin
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.en && !pen) begin
          rises++;
          if (rises == 4) bus.lcd_d = 8'h12;
        end
        pen = bus.en;
      end
      chk("poll_pulses", rises, 4);
    end
    // Limit of two polls with bf stuck high.
    begin
      int   k, rises, dcyc;
      logic pen;
      @(negedge clk);
      k = cyc; rises = 0; pen = 1'b0; dcyc = -1;
      bus2.start = 1'b1; bus2.rs_sel = 1'b0; bus2.lcd_d = 8'hFF;
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        bus2.start = 1'b0;
        if (bus2.en && !pen) rises++;
        pen = bus2.en;
        if (bus2.done === 1'b1) begin
          dcyc = cyc;
          chk("limit_timeout", bus2.timeout, 1);
          chk("limit_rdata", bus2.rdata, 8'hFF);
        end
      end
      chk("limit_pulses", rises, 2);
      chk("limit_done_cycle", dcyc, k + 53);
      chk("limit_timeout_sticky", bus2.timeout, 1);
    end
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
